main_ram_arbiter: RTL and testbench

Four-port arbiter in front of the 32-bit single-port main RAM (32K x 32, byte-write, one-cycle registered read). Shares the RAM between the host CPU bus port and three read-only fetch requesters (layer 0, layer 1, sprite). The CPU has fixed priority. The fetch ports rotate round-robin. A starvation counter guarantees the fetch ports a slot under sustained CPU traffic. The block sits between the requesters and the RAM's slave bus interface.

---
 rtl/main_ram_arbiter_if.sv | 49 ++++
 rtl/main_ram_arbiter.sv | 128 ++++++++++++
 tb/tb_main_ram_arbiter.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_ram_arbiter_if.sv
// Bus bundle between the CPU port, the three fetch requesters, the arbiter
// and the main RAM slave port.
interface main_ram_arbiter_if #(
   parameter int unsigned ADDR_W = 15
);
   // CPU port
   logic                cpu_strobe;
   logic [ADDR_W-1:0]   cpu_addr;
   logic                cpu_write;
   logic [31:0]         cpu_wrdata;
   logic [3:0]          cpu_wrbytesel;
   logic                cpu_ack;
   logic [31:0]         cpu_rddata;
   logic                cpu_rddata_valid;

   // Fetch ports (layer 0, layer 1, sprite)
   logic [2:0]          rq_strobe;
   logic [3*ADDR_W-1:0] rq_addr;
   logic [2:0]          rq_ack;
   logic [31:0]         rq_rddata;
   logic [2:0]          rq_rddata_valid;

   // RAM side
   logic [ADDR_W-1:0]   ram_addr;
   logic [31:0]         ram_wrdata;
   logic [3:0]          ram_wrbytesel;
   logic                ram_write;
   logic [31:0]         ram_rddata;

   // Arbiter view
   modport slave (
      input  cpu_strobe, cpu_addr, cpu_write, cpu_wrdata, cpu_wrbytesel,
      output cpu_ack, cpu_rddata, cpu_rddata_valid,
      input  rq_strobe, rq_addr,
      output rq_ack, rq_rddata, rq_rddata_valid,
      output ram_addr, ram_wrdata, ram_wrbytesel, ram_write,
      input  ram_rddata
   );

   // Requester / RAM view
   modport master (
      output cpu_strobe, cpu_addr, cpu_write, cpu_wrdata, cpu_wrbytesel,
      input  cpu_ack, cpu_rddata, cpu_rddata_valid,
      output rq_strobe, rq_addr,
      input  rq_ack, rq_rddata, rq_rddata_valid,
      input  ram_addr, ram_wrdata, ram_wrbytesel, ram_write,
      output ram_rddata
   );
endinterface

// File: rtl/main_ram_arbiter.sv
// Four-port arbiter for the single-port main RAM: fixed-priority CPU, round-robin
// fetch ports, and a starvation counter that lets a waiting fetch override the CPU.
module main_ram_arbiter #(
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned MAX_WAIT = 4
) (
   input logic               clk,
   input logic               rst_n,
   main_ram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {GntIdle, GntCpu, GntFetch} gnt_e;

   logic [1:0]        rr_last_q, rr_last_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic              cpu_valid_q, cpu_valid_d;
   logic [2:0]        rq_valid_q, rq_valid_d;

   logic [1:0]        rr_first, rr_second, rr_third;
   logic [1:0]        rr_idx;
   logic              rr_found;
   logic              override;
   gnt_e              gnt;
   logic [ADDR_W-1:0] fetch_addr [3];

   for (genvar g = 0; g < 3; g++) begin : g_fetch_addr
      assign fetch_addr[g] = bus.rq_addr[g*ADDR_W +: ADDR_W];
   end

   // Search order starts one past the last fetch grantee and wraps at 3.
   assign rr_first  = (rr_last_q >= 2'd2) ? 2'd0 : rr_last_q + 2'd1;
   assign rr_second = (rr_first  == 2'd2) ? 2'd0 : rr_first  + 2'd1;
   assign rr_third  = (rr_second == 2'd2) ? 2'd0 : rr_second + 2'd1;

   // Round-robin winner among the pending fetch requests.
   always_comb begin
      rr_found = 1'b1;
      rr_idx   = rr_first;
      if (bus.rq_strobe[rr_first]) begin
         rr_idx = rr_first;
      end else if (bus.rq_strobe[rr_second]) begin
         rr_idx = rr_second;
      end else if (bus.rq_strobe[rr_third]) begin
         rr_idx = rr_third;
      end else begin
         rr_found = 1'b0;
      end
   end

   // A fetch denied MAX_WAIT times in favour of the CPU takes the next slot.
   assign override = (MAX_WAIT != 0) && ({24'd0, wait_cnt_q} >= MAX_WAIT) && (|bus.rq_strobe);

   // Grant decision: override, then CPU, then round-robin fetch.
   always_comb begin
      gnt = GntIdle;
      if (override) begin
         gnt = GntFetch;
      end else if (bus.cpu_strobe) begin
         gnt = GntCpu;
      end else if (rr_found) begin
         gnt = GntFetch;
      end
   end

   // Acks and RAM drive for the current grantee; idle drives zeros.
   always_comb begin
      bus.cpu_ack       = 1'b0;
      bus.rq_ack        = 3'b000;
      bus.ram_addr      = '0;
      bus.ram_write     = 1'b0;
      bus.ram_wrdata    = 32'd0;
      bus.ram_wrbytesel = 4'd0;
      unique case (gnt)
         GntCpu: begin
            bus.cpu_ack       = 1'b1;
            bus.ram_addr      = bus.cpu_addr;
            bus.ram_write     = bus.cpu_write;
            bus.ram_wrdata    = bus.cpu_wrdata;
            bus.ram_wrbytesel = bus.cpu_wrbytesel;
         end
         GntFetch: begin
            bus.rq_ack[rr_idx] = 1'b1;
            bus.ram_addr       = fetch_addr[rr_idx];
         end
         default: ;
      endcase
   end

   // Next-state: rotation pointer, starvation counter and read-return tag.
   always_comb begin
      rr_last_d   = rr_last_q;
      wait_cnt_d  = wait_cnt_q;
      cpu_valid_d = 1'b0;
      rq_valid_d  = 3'b000;
      if (gnt == GntFetch) begin
         rr_last_d          = rr_idx;
         wait_cnt_d         = 8'd0;
         rq_valid_d[rr_idx] = 1'b1;
      end else if (gnt == GntCpu) begin
         // A CPU write returns nothing.
         cpu_valid_d = ~bus.cpu_write;
         if ((|bus.rq_strobe) && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
         end
      end
   end

   // State registers; reset also discards any read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q   <= 2'd2;
         wait_cnt_q  <= 8'd0;
         cpu_valid_q <= 1'b0;
         rq_valid_q  <= 3'b000;
      end else begin
         rr_last_q   <= rr_last_d;
         wait_cnt_q  <= wait_cnt_d;
         cpu_valid_q <= cpu_valid_d;
         rq_valid_q  <= rq_valid_d;
      end
   end

   assign bus.cpu_rddata_valid = cpu_valid_q;
   assign bus.rq_rddata_valid  = rq_valid_q;
   assign bus.cpu_rddata       = bus.ram_rddata;
   assign bus.rq_rddata        = bus.ram_rddata;

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Bench for main_ram_arbiter: table of per-cycle stimulus with expected grants,
// a scoreboard queue for the read returns, and a MAX_WAIT=0 instance alongside.
module tb_main_ram_arbiter;

   localparam int unsigned AW = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   main_ram_arbiter_if #(.ADDR_W(AW)) bus ();
   main_ram_arbiter_if #(.ADDR_W(AW)) bus0 ();

   main_ram_arbiter #(.ADDR_W(AW), .MAX_WAIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   main_ram_arbiter #(.ADDR_W(AW), .MAX_WAIT(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   typedef struct {
      logic        cs;
      logic        cw;
      logic [14:0] ca;
      logic [31:0] cd;
      logic [3:0]  cb;
      logic [2:0]  rs;
      logic        e_cack;
      logic [2:0]  e_rack;
   } vec_t;

   typedef struct {
      logic        cv;
      logic [2:0]  rv;
      logic [31:0] data;
   } exp_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb [$];
   vec_t tbl [$];

   // Simple RAM model with a one-cycle registered read.
   logic [31:0] ram_mem [0:32767];
   bit          ram_wr   [0:32767];
   logic [31:0] ref_mem  [0:32767];
   bit          ref_wr   [0:32767];

   function automatic logic [31:0] pat(input logic [14:0] a);
      return 32'hC0DE_0000 ^ {17'd0, a};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] bs);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (bs[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ram_rd(input logic [14:0] a);
      return ram_wr[a] ? ram_mem[a] : pat(a);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [14:0] a);
      return ref_wr[a] ? ref_mem[a] : pat(a);
   endfunction

   always @(posedge clk) begin
      if (bus.ram_write) begin
         ram_mem[bus.ram_addr] <= merge(ram_rd(bus.ram_addr), bus.ram_wrdata, bus.ram_wrbytesel);
         ram_wr[bus.ram_addr]  <= 1'b1;
      end
      bus.ram_rddata <= ram_rd(bus.ram_addr);
   end

   assign bus0.ram_rddata = 32'd0;

   function automatic logic [14:0] faddr(input int i);
      return 15'h0200 + 15'(16 * i) + 15'(cyc);
   endfunction

   function automatic int oh2i(input logic [2:0] oh);
      return oh[0] ? 0 : (oh[1] ? 1 : 2);
   endfunction

   function automatic vec_t mk(input logic cs, input logic cw, input logic [14:0] ca,
                               input logic [31:0] cd, input logic [3:0] cb,
                               input logic [2:0] rs, input logic e_cack,
                               input logic [2:0] e_rack);
      vec_t v;
      v.cs = cs; v.cw = cw; v.ca = ca; v.cd = cd; v.cb = cb;
      v.rs = rs; v.e_cack = e_cack; v.e_rack = e_rack;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      cyc++;
      bus.cpu_strobe    = v.cs;
      bus.cpu_write     = v.cw;
      bus.cpu_addr      = v.ca;
      bus.cpu_wrdata    = v.cd;
      bus.cpu_wrbytesel = v.cb;
      bus.rq_strobe     = v.rs;
      bus.rq_addr       = {faddr(2), faddr(1), faddr(0)};
   endtask

   task automatic check_valid();
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL sb_empty cycle=%0d got=0 want=1", cyc);
         return;
      end
      total--;
      e = sb.pop_front();
      chk("cpu_rddata_valid", 64'(bus.cpu_rddata_valid), 64'(e.cv));
      chk("rq_rddata_valid", 64'(bus.rq_rddata_valid), 64'(e.rv));
      if (e.cv) chk("cpu_rddata", 64'(bus.cpu_rddata), 64'(e.data));
      if (|e.rv) chk("rq_rddata", 64'(bus.rq_rddata), 64'(e.data));
   endtask

   // Compare grant outputs now and queue the read return for next cycle.
   task automatic observe(input vec_t v);
      logic [14:0] ea;
      logic        ew;
      logic [31:0] ed;
      logic [3:0]  eb;
      exp_t        e;
      check_valid();
      chk("cpu_ack", 64'(bus.cpu_ack), 64'(v.e_cack));
      chk("rq_ack", 64'(bus.rq_ack), 64'(v.e_rack));
      ea = '0; ew = 1'b0; ed = '0; eb = '0;
      if (v.e_cack) begin
         ea = v.ca; ew = v.cw; ed = v.cd; eb = v.cb;
      end else if (|v.e_rack) begin
         ea = faddr(oh2i(v.e_rack));
      end
      chk("ram_drive", 64'({ea, ew, ed, eb}),
          64'({bus.ram_addr, bus.ram_write, bus.ram_wrdata, bus.ram_wrbytesel}) ^ 64'd0 ^
          64'({bus.ram_addr, bus.ram_write, bus.ram_wrdata, bus.ram_wrbytesel}) ^
          64'({bus.ram_addr, bus.ram_write, bus.ram_wrdata, bus.ram_wrbytesel}));
      chk("nowait_rq_ack", 64'(bus0.rq_ack), 64'd0);
      chk("nowait_cpu_ack", 64'(bus0.cpu_ack), 64'd1);
      e.cv = v.e_cack & ~v.cw;
      e.rv = v.e_rack;
      e.data = 32'd0;
      if (e.cv) e.data = ref_rd(v.ca);
      else if (|v.e_rack) e.data = ref_rd(faddr(oh2i(v.e_rack)));
      if (v.e_cack && v.cw) begin
         ref_mem[v.ca] = merge(ref_rd(v.ca), v.cd, v.cb);
         ref_wr[v.ca]  = 1'b1;
      end
      sb.push_back(e);
   endtask

   task automatic step(input vec_t v);
      drive(v);
      @(negedge clk);
      observe(v);
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t none_exp();
      exp_t e;
      e.cv = 1'b0; e.rv = 3'b000; e.data = 32'd0;
      return e;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t idle;
      vec_t v;
      idle = mk(0, 0, 15'h0, 32'h0, 4'h0, 3'b000, 0, 3'b000);

      // Reset-then-fetch: 111 rotates 0, 1, 2, 0.
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(0, 0, 15'h0, 32'h0, 4'h0, 3'b111, 0, 3'(1 << (i % 3))));
      // CPU write then read back of the same word.
      tbl.push_back(mk(1, 1, 15'h0123, 32'hA5A5_1234, 4'b0101, 3'b000, 1, 3'b000));
      tbl.push_back(mk(1, 0, 15'h0123, 32'hFFFF_0000, 4'b0000, 3'b000, 1, 3'b000));
      tbl.push_back(idle);
      // 101 under no CPU alternates between 2 and 0 (last grantee was 0).
      tbl.push_back(mk(0, 0, 15'h0, 32'h0, 4'h0, 3'b101, 0, 3'b100));
      tbl.push_back(mk(0, 0, 15'h0, 32'h0, 4'h0, 3'b101, 0, 3'b001));
      tbl.push_back(mk(0, 0, 15'h0, 32'h0, 4'h0, 3'b101, 0, 3'b100));
      tbl.push_back(mk(0, 0, 15'h0, 32'h0, 4'h0, 3'b101, 0, 3'b001));
      // Starvation: CPU wins 4 times, fetch 1 then overrides, CPU resumes.
      for (int i = 0; i < 4; i++)
         tbl.push_back(mk(1, 0, 15'h0040, 32'h0, 4'h0, 3'b010, 1, 3'b000));
      tbl.push_back(mk(1, 0, 15'h0040, 32'h0, 4'h0, 3'b010, 0, 3'b010));
      tbl.push_back(mk(1, 0, 15'h0041, 32'h0, 4'h0, 3'b000, 1, 3'b000));
      tbl.push_back(idle);
      // Contention with a CPU write, fetch strobe dropped, then re-presented.
      tbl.push_back(mk(1, 1, 15'h0055, 32'h1122_3344, 4'b1111, 3'b100, 1, 3'b000));
      tbl.push_back(idle);
      tbl.push_back(mk(0, 0, 15'h0, 32'h0, 4'h0, 3'b100, 0, 3'b100));
      tbl.push_back(mk(1, 0, 15'h0055, 32'h0, 4'h0, 3'b000, 1, 3'b000));
      tbl.push_back(idle);

      drive(idle);
      bus0.cpu_strobe    = 1'b1;
      bus0.cpu_write     = 1'b0;
      bus0.cpu_addr      = 15'h0010;
      bus0.cpu_wrdata    = 32'd0;
      bus0.cpu_wrbytesel = 4'd0;
      bus0.rq_strobe     = 3'b010;
      bus0.rq_addr       = '0;

      @(negedge clk);
      chk("reset_cpu_valid", 64'(bus.cpu_rddata_valid), 64'd0);
      chk("reset_rq_valid", 64'(bus.rq_rddata_valid), 64'd0);
      chk("reset_nowait_rq_valid", 64'(bus0.rq_rddata_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.push_back(none_exp());

      foreach (tbl[i]) step(tbl[i]);

      // Reset between a fetch ack and its valid cycle.
      v = mk(0, 0, 15'h0, 32'h0, 4'h0, 3'b001, 0, 3'b001);
      drive(v);
      @(negedge clk);
      observe(v);
      #2;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      drive(idle);
      chk("midreset_rq_valid", 64'(bus.rq_rddata_valid), 64'd0);
      chk("midreset_cpu_valid", 64'(bus.cpu_rddata_valid), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb.delete();
      sb.push_back(none_exp());
      // Pointer back at 2, so requester 0 is searched first.
      step(mk(0, 0, 15'h0, 32'h0, 4'h0, 3'b111, 0, 3'b001));
      step(mk(0, 0, 15'h0, 32'h0, 4'h0, 3'b110, 0, 3'b010));
      step(idle);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
